iter_alu: RTL and testbench

- Parametrised, handshaked successor to the processor's combinational ALU.
- Keeps the eight single-cycle operations (ADD through SRL) and adds iterative unsigned multiply (low and high word), divide and remainder.
- Results and flags are registered and held until the consumer accepts them.
- Sits between the execute-stage operand muxes and writeback. The pipeline stalls on in_ready/out_valid.

---
 rtl/iter_alu.sv | 206 ++++++++++++++++++++
 tb/tb_iter_alu.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: handshaked ALU with single-cycle logic/arith ops and iterative
// unsigned multiply (low/high word), divide and remainder.
// Optional build macro: ITER_ALU_EARLY_TERM_EN -- lets MUL/MULHU leave the
// multiply loop once the remaining multiplier bits are all zero.
module iter_alu #(
   parameter int WIDTH      = 32,
   parameter int CTRL_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_WIDTH-1:0] alu_control,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      alu_result,
   output logic                  carry,
   output logic                  over_flow,
   output logic                  zero,
   output logic                  busy
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               carry_q, carry_d, ovf_q, ovf_d;

   // Only the low four opcode bits are decoded; the rest are ignored.
   logic               unused_ctrl;
   assign unused_ctrl = ^alu_control;

   logic [3:0]         op_in;
   assign op_in = alu_control[3:0];

   // Single-cycle results, computed straight from the incoming operands.
   logic               is_sub;
   logic [WIDTH-1:0]   b_addend;
   logic [WIDTH:0]     add_full;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_carry, sc_ovf;

   // Single-cycle datapath: one shared adder for ADD/SUB plus logic/shift ops.
   always_comb begin
      is_sub   = (op_in == 4'd1);
      b_addend = is_sub ? ~b : b;
      add_full = {1'b0, a} + {1'b0, b_addend} + {{WIDTH{1'b0}}, is_sub};
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      case (op_in)
         4'd0, 4'd1: begin
            sc_res   = add_full[WIDTH-1:0];
            sc_carry = add_full[WIDTH];
            sc_ovf   = (add_full[WIDTH-1] ^ a[WIDTH-1]) &
                       ~(is_sub ^ b[WIDTH-1] ^ a[WIDTH-1]);
         end
         4'd2:    sc_res = a & b;
         4'd3:    sc_res = a | b;
         4'd4:    sc_res = a ^ b;
         4'd5:    sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
         4'd6:    sc_res = a << b[SW-1:0];
         4'd7:    sc_res = a >> b[SW-1:0];
         default: sc_res = '0;
      endcase
   end

   // One iteration of the shift-add multiplier and the restoring divider.
   // Multiply: acc = {partial product, unconsumed multiplier bits}.
   // Divide:   acc = {partial remainder, dividend/quotient bits}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, mul_fin;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [CW-1:0]      cnt_nxt;
   logic               mul_last;

   // Iteration step logic and loop-exit decision.
   always_comb begin
      cnt_nxt   = cnt_q + 1'b1;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = {1'b0, div_shift} - {2'b00, b_q};
      if (div_diff[WIDTH+1])
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`ifdef ITER_ALU_EARLY_TERM_EN
      // Skipped iterations would only shift right, so apply them in one go.
      mul_last = (cnt_nxt == CW'(WIDTH)) || ((b_q >> 1) == '0);
      mul_fin  = mul_next >> (CW'(WIDTH) - cnt_nxt);
`else
      mul_last = (cnt_nxt == CW'(WIDTH));
      mul_fin  = mul_next;
`endif
   end

   // Next-state and datapath register loads.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d  = op_in;
               a_d   = a;
               b_d   = b;
               cnt_d = '0;
               case (op_in)
                  4'd8, 4'd9: begin
                     acc_d   = {{WIDTH{1'b0}}, b};
                     state_d = S_MUL;
                  end
                  4'd10, 4'd11: begin
                     acc_d   = {{WIDTH{1'b0}}, a};
                     state_d = S_DIV;
                  end
                  default: begin
                     res_d   = sc_res;
                     carry_d = sc_carry;
                     ovf_d   = sc_ovf;
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_MUL: begin
            acc_d = mul_next;
            b_d   = b_q >> 1;
            cnt_d = cnt_nxt;
            if (mul_last) begin
               res_d   = (op_q == 4'd8) ? mul_fin[WIDTH-1:0] : mul_fin[2*WIDTH-1:WIDTH];
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_nxt;
            if (cnt_nxt == CW'(WIDTH)) begin
               res_d   = (op_q == 4'd10) ? div_next[WIDTH-1:0] : div_next[2*WIDTH-1:WIDTH];
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         default: begin
            if (out_ready)
               state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
   assign alu_result = res_q;
   assign carry      = carry_q;
   assign over_flow  = ovf_q;
   assign zero       = (res_q == '0);

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32) against a behavioural model.
module tb_iter_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_result;
   logic        carry, over_flow, zero, busy;

   int n_tests = 0;
   int n_fail  = 0;

   iter_alu #(.WIDTH(32), .CTRL_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .alu_result(alu_result), .carry(carry),
      .over_flow(over_flow), .zero(zero), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: plain arithmetic on the operation's definition.
   function automatic void model(input logic [3:0] op, input logic [31:0] av, bv,
                                 output logic [31:0] r, output logic c, output logic v);
      logic [63:0] prod;
      logic [32:0] s;
      r = 32'd0; c = 1'b0; v = 1'b0;
      prod = 64'(av) * 64'(bv);
      case (op)
         4'd0: begin
            s = 33'(av) + 33'(bv);
            r = s[31:0]; c = s[32];
            v = (av[31] == bv[31]) && (r[31] != av[31]);
         end
         4'd1: begin
            r = av - bv; c = (av >= bv);
            v = (av[31] != bv[31]) && (r[31] != av[31]);
         end
         4'd2: r = av & bv;
         4'd3: r = av | bv;
         4'd4: r = av ^ bv;
         4'd5: r = (av < bv) ? 32'd1 : 32'd0;
         4'd6: r = av << bv[4:0];
         4'd7: r = av >> bv[4:0];
         4'd8: r = prod[31:0];
         4'd9: r = prod[63:32];
         4'd10: r = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
         4'd11: r = (bv == 0) ? av : av % bv;
         default: r = 32'd0;
      endcase
   endfunction

   // Expected cycles from accept edge to out_valid high.
   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] bv);
      if (op == 4'd8 || op == 4'd9) begin
`ifdef ITER_ALU_EARLY_TERM_EN
         int h;
         h = 0;
         for (int i = 0; i < 32; i++) if (bv[i]) h = i;
         return h + 2;
`else
         return 33;
`endif
      end
      if (op == 4'd10 || op == 4'd11) return 33;
      return 1;
   endfunction

   // Issue one operation, scramble inputs after accept, wait for the result
   // with out_ready=1, and return its fields and observed latency (-1 on timeout).
   task automatic do_op(input logic [3:0] op, input logic [31:0] av, bv,
                        output logic [31:0] r, output logic c, v, z, output int lat);
      alu_control = op; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
      lat = -1;
      r = 'x; c = 1'bx; v = 1'bx; z = 1'bx;
      for (int i = 1; i <= 100; i++) begin
         if (out_valid) begin
            lat = i;
            r = alu_result; c = carry; v = over_flow; z = zero;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat > 0) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_control = 4'd0; a = 0; b = 0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready, out_valid, busy, carry, over_flow, zero} !== 6'b100001 || alu_result !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b vld=%b busy=%b c=%b v=%b z=%b res=%h, expected 1 0 0 0 0 1 00000000",
                  in_ready, out_valid, busy, carry, over_flow, zero, alu_result);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] av, bv);
      logic [31:0] r, er;
      logic c, v, z, ec, ev;
      int lat, el;
      model(op, av, bv, er, ec, ev);
      el = exp_lat(op, bv);
      do_op(op, av, bv, r, c, v, z, lat);
      n_tests++;
      if (r !== er || c !== ec || v !== ev || z !== (er == 0) || lat != el) begin
         n_fail++;
         $display("FAIL %s: op=%0d a=%h b=%h got res=%h c=%b v=%b z=%b lat=%0d, expected res=%h c=%b v=%b z=%b lat=%0d",
                  name, op, av, bv, r, c, v, z, lat, er, ec, ev, (er == 0), el);
      end else
         $display("[TB] %s op=%0d a=%h b=%h res=%h lat=%0d ok", name, op, av, bv, r, lat);
   endtask

   task automatic test_directed();
      logic [31:0] r;
      logic c, v, z;
      int lat;
      // Literal expectations straight from the operation definitions.
      do_op(4'd0, 32'h7FFF_FFFF, 32'd1, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'h8000_0000 || v !== 1'b1 || c !== 1'b0 || z !== 1'b0 || lat != 1) begin
         n_fail++;
         $display("FAIL add_ovf: got res=%h v=%b c=%b z=%b lat=%0d, expected 80000000 1 0 0 1", r, v, c, z, lat);
      end
      do_op(4'd1, 32'd5, 32'd5, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'd0 || z !== 1'b1 || c !== 1'b1 || v !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_eq: got res=%h z=%b c=%b v=%b, expected 00000000 1 1 0", r, z, c, v);
      end
      do_op(4'd1, 32'd0, 32'd1, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'hFFFF_FFFF || c !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_borrow: got res=%h c=%b, expected FFFFFFFF 0", r, c);
      end
      do_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'hFFFF_FFFE || lat != 33) begin
         n_fail++;
         $display("FAIL mulhu_max: got res=%h lat=%0d, expected FFFFFFFE 33", r, lat);
      end
      do_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL mul_max: got res=%h, expected 00000001", r);
      end
      do_op(4'd10, 32'd100, 32'd7, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'd14 || lat != 33) begin
         n_fail++;
         $display("FAIL divu: got res=%h lat=%0d, expected 0000000e 33", r, lat);
      end
      do_op(4'd11, 32'd100, 32'd7, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'd2) begin
         n_fail++;
         $display("FAIL remu: got res=%h, expected 00000002", r);
      end
      do_op(4'd10, 32'd9, 32'd0, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'hFFFF_FFFF || lat != 33) begin
         n_fail++;
         $display("FAIL divu_by0: got res=%h lat=%0d, expected FFFFFFFF 33", r, lat);
      end
      do_op(4'd11, 32'd9, 32'd0, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'd9) begin
         n_fail++;
         $display("FAIL remu_by0: got res=%h, expected 00000009", r);
      end
      do_op(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'd0 || z !== 1'b1 || c !== 1'b0 || v !== 1'b0 || lat != 1) begin
         n_fail++;
         $display("FAIL undef_op: got res=%h z=%b c=%b v=%b lat=%0d, expected 0 1 0 0 1", r, z, c, v, lat);
      end
`ifdef ITER_ALU_EARLY_TERM_EN
      do_op(4'd8, 32'd3, 32'd2, r, c, v, z, lat);
      n_tests++;
      if (r !== 32'd6 || lat != 3) begin
         n_fail++;
         $display("FAIL mul_early: got res=%h lat=%0d, expected 00000006 3", r, lat);
      end
`endif
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] av, bv;
      for (int i = 0; i < 48; i++) begin
         op = (i < 16) ? 4'(i) : 4'($urandom);
         av = $urandom;
         bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         check_op("random", op, av, bv);
      end
   endtask

   task automatic test_backpressure();
      alu_control = 4'd6; a = 32'd1; b = 32'h25; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom;
      for (int i = 0; i < 10; i++) begin
         n_tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== 32'h20) begin
            n_fail++;
            $display("FAIL backpressure_hold: cycle %0d got vld=%b rdy=%b res=%h, expected 1 0 00000020",
                     i, out_valid, in_ready, alu_result);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_release: got rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
      end else
         $display("[TB] backpressure SLL held 10 cycles then consumed");
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; alu_control = 4'd0; a = 32'd10; b = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd7; b = 32'd8;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== 32'd30) begin
         n_fail++;
         $display("FAIL b2b_first: got vld=%b rdy=%b res=%h, expected 1 0 0000001e", out_valid, in_ready, alu_result);
      end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== 32'd30) begin
         n_fail++;
         $display("FAIL b2b_gap: got vld=%b rdy=%b res=%h, expected 0 1 0000001e", out_valid, in_ready, alu_result);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || alu_result !== 32'd15) begin
         n_fail++;
         $display("FAIL b2b_second: got vld=%b res=%h, expected 1 0000000f", out_valid, alu_result);
      end else
         $display("[TB] back_to_back ADD 30 then 15");
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midop();
      bit seen;
      out_ready = 1'b1; alu_control = 4'd10; a = $urandom; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_busy: got busy=%b, expected 1", busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || zero !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_reset: got busy=%b vld=%b rdy=%b z=%b, expected 0 0 1 1", busy, out_valid, in_ready, zero);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_no_result: got out_valid seen=%b, expected 0", seen);
      end else
         $display("[TB] reset mid-DIVU abandoned the operation");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
